// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory load/store unit.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_BAD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Natural alignment check; an illegal size is flagged separately.
  function automatic logic misaligned(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_H:    return addr_lo[0];
      SZ_W:    return (addr_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Selects the addressed byte/half of a little-endian word and sign/zero-extends it.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension by access size.
  always_comb begin
    byte_s = word[{addr_lo, 3'b000} +: 8];
    half_s = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    data = {{24{~is_unsigned & byte_s[7]}}, byte_s};
      SZ_H:    data = {{16{~is_unsigned & half_s[15]}}, half_s};
      SZ_W:    data = word;
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressable data memory with a valid/ready load/store front end,
// configurable load latency, load extension and error reporting.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_BYTES    = 131072,
  parameter int BASE_ADDR    = 0,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "",
  parameter int INIT_OFFSET  = 'h10000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int                    IDX_W  = $clog2(MEM_BYTES) - 2;
  localparam logic [ADDR_WIDTH-1:0] BASE_W = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   SIZE_W = (ADDR_WIDTH + 1)'(MEM_BYTES);
  localparam logic [2:0]            RL_W   = 3'(READ_LATENCY);

  logic [31:0] mem_r [MEM_BYTES/4];

  state_e           state_r;
  logic [1:0]       cnt_r;
  logic [IDX_W-1:0] idx_r;
  logic [1:0]       lo_r;
  size_e            size_r;
  logic             uns_r;
  logic             rsp_valid_r;
  logic [31:0]      rsp_rdata_r;
  logic             rsp_err_r;

  size_e                 size_s;
  logic                  req_ready_s;
  logic                  accept_s;
  logic [ADDR_WIDTH-1:0] offset_s;
  logic                  err_s;
  logic                  good_load_s;
  logic [2:0]            lat_s;
  logic [IDX_W-1:0]      wr_idx_s;
  logic [3:0]            be_s;
  logic [31:0]           wdata_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic [1:0]            rd_lo_s;
  size_e                 rd_size_s;
  logic                  rd_uns_s;
  logic [31:0]           rd_data_s;

  // Request decode: acceptance, error classification, latency and store lanes.
  always_comb begin
    size_s      = size_e'(req_size);
    req_ready_s = (state_r != WAIT);
    accept_s    = req_valid && req_ready_s;
    offset_s    = req_addr - BASE_W;
    // Addresses below the base wrap around and are caught by the same test.
    err_s       = (size_s == SZ_BAD) || misaligned(size_s, req_addr[1:0]) ||
                  (req_addr < BASE_W) || ({1'b0, offset_s} >= SIZE_W);
    good_load_s = !req_we && !err_s;
    lat_s       = good_load_s ? RL_W : 3'd1;
    wr_idx_s    = offset_s[IDX_W+1:2];
    case (size_s)
      SZ_B: begin
        be_s    = 4'b0001 << req_addr[1:0];
        wdata_s = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        be_s    = 4'b0011 << req_addr[1:0];
        wdata_s = {2{req_wdata[15:0]}};
      end
      SZ_W: begin
        be_s    = 4'b1111;
        wdata_s = req_wdata;
      end
      default: begin
        be_s    = 4'b0000;
        wdata_s = req_wdata;
      end
    endcase
  end

  // Read port uses the live request for single-cycle loads, the latched one in WAIT.
  always_comb begin
    if (state_r == WAIT) begin
      rd_idx_s  = idx_r;
      rd_lo_s   = lo_r;
      rd_size_s = size_r;
      rd_uns_s  = uns_r;
    end else begin
      rd_idx_s  = wr_idx_s;
      rd_lo_s   = req_addr[1:0];
      rd_size_s = size_s;
      rd_uns_s  = req_unsigned;
    end
  end

  dmem_load_ext u_load_ext (
    .word        (mem_r[rd_idx_s]),
    .addr_lo     (rd_lo_s),
    .size        (rd_size_s),
    .is_unsigned (rd_uns_s),
    .data        (rd_data_s)
  );

  // Byte-enabled store at the accept edge; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (rst_n && accept_s && req_we && !err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[wr_idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  // Control FSM and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 2'd0;
      idx_r       <= '0;
      lo_r        <= 2'd0;
      size_r      <= SZ_B;
      uns_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
      case (state_r)
        IDLE, RESP: begin
          if (accept_s) begin
            idx_r  <= wr_idx_s;
            lo_r   <= req_addr[1:0];
            size_r <= size_s;
            uns_r  <= req_unsigned;
            if (lat_s == 3'd1) begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= err_s;
              rsp_rdata_r <= good_load_s ? rd_data_s : 32'h0000_0000;
            end else begin
              state_r <= WAIT;
              cnt_r   <= 2'(lat_s - 3'd1);
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (cnt_r == 2'd1) begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= rd_data_s;
          end else begin
            cnt_r <= cnt_r - 2'd1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench: one instance with single-cycle loads, one with three-cycle loads.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid1 = 1'b0, valid3 = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'd0;
  logic        uns = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready1, ready3, rsp_valid1, rsp_valid3, err1, err3;
  logic [31:0] rdata1, rdata3;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid1), .req_ready(ready1),
    .req_we(we), .req_size(size), .req_unsigned(uns), .req_addr(addr),
    .req_wdata(wdata), .rsp_valid(rsp_valid1), .rsp_rdata(rdata1), .rsp_err(err1)
  );

  dmem_lsu #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid3), .req_ready(ready3),
    .req_we(we), .req_size(size), .req_unsigned(uns), .req_addr(addr),
    .req_wdata(wdata), .rsp_valid(rsp_valid3), .rsp_rdata(rdata3), .rsp_err(err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request and waits (bounded) for its response; cyc counts negedges after accept.
  task automatic req(input bit sel3, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d,
                     output int cyc, output logic [31:0] rd, output logic er);
    @(negedge clk);
    we = w; size = sz; uns = u; addr = a; wdata = d;
    if (sel3) valid3 = 1'b1; else valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid1 = 1'b0; valid3 = 1'b0;
    cyc = 1;
    while (!(sel3 ? rsp_valid3 : rsp_valid1) && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    rd = sel3 ? rdata3 : rdata1;
    er = sel3 ? err3 : err1;
  endtask

  initial begin
    int cyc;
    logic [31:0] rd, rd_a, rd_b;
    logic er, seen;
    logic [6:0] rdy_v, vld_v;

    #12;
    check("rst_ready", {31'd0, ready1}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid1}, 32'd0);
    check("rst_rdata", rdata1, 32'h0);
    check("rst_err", {31'd0, err1}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    req(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, cyc, rd, er);
    check("st_word_lat", cyc, 32'd1);
    check("st_word_rdata", rd, 32'h0);
    check("st_word_err", {31'd0, er}, 32'd0);
    req(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, cyc, rd, er);
    check("ld_word_lat", cyc, 32'd1);
    check("ld_word", rd, 32'hDEADBEEF);
    req(1'b0, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0, cyc, rd, er);
    check("ld_byte_s", rd, 32'hFFFFFFBE);
    req(1'b0, 1'b0, 2'd0, 1'b1, 32'h101, 32'h0, cyc, rd, er);
    check("ld_byte_u", rd, 32'h000000BE);
    req(1'b0, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, cyc, rd, er);
    check("ld_half_s", rd, 32'hFFFFDEAD);
    req(1'b0, 1'b0, 2'd1, 1'b1, 32'h100, 32'h0, cyc, rd, er);
    check("ld_half_u", rd, 32'h0000BEEF);
    req(1'b0, 1'b1, 2'd1, 1'b0, 32'h100, 32'hFFFF1234, cyc, rd, er);
    req(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, cyc, rd, er);
    check("ld_after_half_st", rd, 32'hDEAD1234);
    req(1'b0, 1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5, cyc, rd, er);
    req(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, cyc, rd, er);
    check("ld_after_byte_st", rd, 32'hA5AD1234);

    // Error cases: each responds in one cycle with err set and zero data.
    req(1'b0, 1'b0, 2'd1, 1'b0, 32'h103, 32'h0, cyc, rd, er);
    check("mis_half_err", {31'd0, er}, 32'd1);
    check("mis_half_rdata", rd, 32'h0);
    check("mis_half_lat", cyc, 32'd1);
    req(1'b0, 1'b1, 2'd2, 1'b0, 32'h102, 32'hFFFFFFFF, cyc, rd, er);
    check("mis_word_st_err", {31'd0, er}, 32'd1);
    req(1'b0, 1'b1, 2'd3, 1'b0, 32'h100, 32'h01010101, cyc, rd, er);
    check("bad_size_st_err", {31'd0, er}, 32'd1);
    req(1'b0, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, cyc, rd, er);
    check("bad_size_ld_err", {31'd0, er}, 32'd1);
    check("bad_size_ld_rdata", rd, 32'h0);
    req(1'b0, 1'b1, 2'd2, 1'b0, 32'h20000, 32'h77777777, cyc, rd, er);
    check("oor_st_err", {31'd0, er}, 32'd1);
    req(1'b0, 1'b0, 2'd2, 1'b0, 32'h20000, 32'h0, cyc, rd, er);
    check("oor_ld_err", {31'd0, er}, 32'd1);
    check("oor_ld_rdata", rd, 32'h0);
    req(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, cyc, rd, er);
    check("mem_unchanged", rd, 32'hA5AD1234);
    check("mem_unchanged_err", {31'd0, er}, 32'd0);
    req(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, cyc, rd, er);
    check("oor_no_alias", rd[31:0] == 32'h77777777 ? 32'd1 : 32'd0, 32'd0);
    req(1'b0, 1'b1, 2'd2, 1'b0, 32'h1FFFC, 32'h5A5A0001, cyc, rd, er);
    check("top_word_st_err", {31'd0, er}, 32'd0);
    req(1'b0, 1'b0, 2'd2, 1'b0, 32'h1FFFC, 32'h0, cyc, rd, er);
    check("top_word_ld", rd, 32'h5A5A0001);

    // Read-after-write: load accepted in the store's response cycle.
    @(negedge clk);
    we = 1'b1; size = 2'd2; addr = 32'h108; wdata = 32'h11223344; valid1 = 1'b1;
    @(negedge clk);
    check("raw_st_rsp", {31'd0, rsp_valid1}, 32'd1);
    we = 1'b0;
    @(negedge clk);
    valid1 = 1'b0;
    check("raw_ld_rsp", {31'd0, rsp_valid1}, 32'd1);
    check("raw_ld_data", rdata1, 32'h11223344);

    // Three-cycle instance: store, then back-to-back held loads.
    req(1'b1, 1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFEF00D, cyc, rd, er);
    check("l3_st_lat", cyc, 32'd1);
    @(negedge clk);
    we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h200; valid3 = 1'b1;
    rd_a = 32'h0; rd_b = 32'h0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      rdy_v[i-1] = ready3;
      vld_v[i-1] = rsp_valid3;
      if (i == 3) rd_a = rdata3;
      if (i == 6) begin
        rd_b = rdata3;
        valid3 = 1'b0;
      end
    end
    check("b2b_ready_seq", {25'd0, rdy_v}, {25'd0, 7'b1100100});
    check("b2b_valid_seq", {25'd0, vld_v}, {25'd0, 7'b0100100});
    check("b2b_rdata_a", rd_a, 32'hCAFEF00D);
    check("b2b_rdata_b", rd_b, 32'hCAFEF00D);
    req(1'b1, 1'b0, 2'd0, 1'b0, 32'h203, 32'h0, cyc, rd, er);
    check("l3_byte_lat", cyc, 32'd3);
    check("l3_byte_s", rd, 32'hFFFFFFCA);
    req(1'b1, 1'b0, 2'd2, 1'b0, 32'h202, 32'h0, cyc, rd, er);
    check("l3_err_lat", cyc, 32'd1);
    check("l3_err", {31'd0, er}, 32'd1);

    // Reset while a three-cycle load is waiting.
    @(negedge clk);
    we = 1'b0; size = 2'd2; addr = 32'h200; valid3 = 1'b1;
    @(negedge clk);
    valid3 = 1'b0;
    check("wait_ready_low", {31'd0, ready3}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_wait_ready", {31'd0, ready3}, 32'd1);
    check("rst_wait_valid", {31'd0, rsp_valid3}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | rsp_valid3;
    end
    check("rst_no_rsp", {31'd0, seen}, 32'd0);
    req(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, cyc, rd, er);
    check("post_rst_lat", cyc, 32'd3);
    check("post_rst_data", rd, 32'hCAFEF00D);
    req(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, cyc, rd, er);
    check("mem_kept_rst", rd, 32'hA5AD1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
